// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the Wishbone control block: register offsets,
// CTRL/STATUS field positions, the base-window mask and a byte-lane helper.
package wb_ctrl_pkg;

    localparam logic [7:0]  OFF_IMEM_WRITE  = 8'h00;
    localparam logic [7:0]  OFF_CTRL        = 8'h04;
    localparam logic [7:0]  OFF_STATUS      = 8'h08;
    localparam logic [7:0]  OFF_IMEM_PTR    = 8'h0C;
    localparam logic [7:0]  OFF_IMEM_STREAM = 8'h10;
    localparam logic [7:0]  OFF_CFG0        = 8'h20;

    localparam int          CTRL_RUN_BIT    = 0;
    localparam int          STATUS_CNT_W    = 16;
    localparam int          STATUS_RUN_BIT  = 16;

    // Address bits above the decoded offset byte must match the base
    localparam logic [31:0] WIN_MASK        = 32'hFFFF_FF00;

    // Byte lanes that cover bits [nbits-1:0] of a 32-bit word
    function automatic logic [3:0] lane_mask(input int nbits);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) m[k] = (k * 8 < nbits);
        return m;
    endfunction

endpackage

// File: rtl/wb_ctrl_bytereg.sv
// Register of parametrised width with per-byte write enables and a
// parametrised reset value. Bit i is written when lane i/8 is selected.
module wb_ctrl_bytereg #(
    parameter int           W   = 32,
    parameter logic [W-1:0] RST = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [(W+7)/8-1:0]   i_sel,
    input  logic [W-1:0]         i_d,
    output logic [W-1:0]         o_q
);

    logic [W-1:0] r_q;

    // Synchronous reset, then byte-lane masked write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RST;
        end else if (i_we) begin
            for (int i = 0; i < W; i++) begin
                if (i_sel[i / 8]) r_q[i] <= i_d[i];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/wb_ctrl_regs.sv
// Wishbone classic slave for the jacaranda-8 host control block: IMEM write
// port, core run control, status readback and byte-writable config registers.
// Optional feature macro: WB_CTRL_IMEM_AUTOINC_EN (IMEM_PTR + IMEM_STREAM).
// All register side effects land on the accept edge, so they are visible in
// the same cycle the ack is presented.
module wb_ctrl_regs
    import wb_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IMEM_AW   = 8,
    parameter int          IMEM_DW   = 8,
    parameter int          NUM_CFG   = 4,
    parameter logic [31:0] CFG0_RST  = 32'd0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [IMEM_AW-1:0]      imem_addr_o,
    output logic [IMEM_DW-1:0]      imem_data_o,
    output logic                    imem_we_o,
    output logic                    core_run_o,
    output logic [32*NUM_CFG-1:0]   cfg_o
);

    localparam logic [3:0] IMEM_LANES = lane_mask(IMEM_AW + IMEM_DW);

    logic                     r_ack;
    logic [31:0]              r_dat;
    logic                     r_imem_we;
    logic [IMEM_AW-1:0]       r_imem_addr;
    logic [IMEM_DW-1:0]       r_imem_data;
    logic [STATUS_CNT_W-1:0]  r_cnt;

    logic                     w_acc;
    logic                     w_in_win;
    logic [7:0]               w_off;
    logic                     w_wr;
    logic                     w_imem_direct;
    logic                     w_imem_fire;
    logic [IMEM_AW-1:0]       w_imem_addr_nxt;
    logic                     w_run;
    logic [31:0]              w_rdata;
    logic [NUM_CFG-1:0][31:0] w_cfg;

    // A new access is taken only while no ack is outstanding
    assign w_acc    = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_in_win = (wbs_adr_i & WIN_MASK) == (BASE_ADDR & WIN_MASK);
    assign w_off    = wbs_adr_i[7:0];
    assign w_wr     = w_acc & wbs_we_i & w_in_win;

    // Direct IMEM write needs every lane covering the addr+data field
    assign w_imem_direct = w_wr && (w_off == OFF_IMEM_WRITE)
                           && ((wbs_sel_i & IMEM_LANES) == IMEM_LANES);

    wb_ctrl_bytereg #(.W(1), .RST(1'b0)) u_ctrl (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_we  (w_wr && (w_off == OFF_CTRL)),
        .i_sel (wbs_sel_i[0]),
        .i_d   (wbs_dat_i[CTRL_RUN_BIT]),
        .o_q   (w_run)
    );

    genvar g;
    generate
        for (g = 0; g < NUM_CFG; g++) begin : g_cfg
            localparam logic [7:0]  OFF = OFF_CFG0 + 8'(4 * g);
            localparam logic [31:0] RV  = (g == 0) ? CFG0_RST : 32'd0;
            wb_ctrl_bytereg #(.W(32), .RST(RV)) u_cfg (
                .i_clk (wb_clk_i),
                .i_rst (wb_rst_i),
                .i_we  (w_wr && (w_off == OFF)),
                .i_sel (wbs_sel_i),
                .i_d   (wbs_dat_i),
                .o_q   (w_cfg[g])
            );
        end
    endgenerate

`ifdef WB_CTRL_IMEM_AUTOINC_EN
    localparam int PTR_NB = (IMEM_AW + 7) / 8;

    logic                w_stream;
    logic [IMEM_AW-1:0]  w_ptr;
    logic [PTR_NB-1:0]   w_ptr_sel;
    logic [IMEM_AW-1:0]  w_ptr_d;

    // A stream write reuses the pointer's write port to post-increment it
    assign w_stream  = w_wr && (w_off == OFF_IMEM_STREAM) && wbs_sel_i[0];
    assign w_ptr_sel = w_stream ? {PTR_NB{1'b1}} : wbs_sel_i[PTR_NB-1:0];
    assign w_ptr_d   = w_stream ? (w_ptr + IMEM_AW'(1)) : wbs_dat_i[IMEM_AW-1:0];

    wb_ctrl_bytereg #(.W(IMEM_AW), .RST('0)) u_ptr (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_we  (w_stream || (w_wr && (w_off == OFF_IMEM_PTR))),
        .i_sel (w_ptr_sel),
        .i_d   (w_ptr_d),
        .o_q   (w_ptr)
    );

    assign w_imem_fire     = w_imem_direct | w_stream;
    assign w_imem_addr_nxt = w_stream ? w_ptr
                                      : wbs_dat_i[IMEM_AW+IMEM_DW-1:IMEM_DW];
`else
    assign w_imem_fire     = w_imem_direct;
    assign w_imem_addr_nxt = wbs_dat_i[IMEM_AW+IMEM_DW-1:IMEM_DW];
`endif

    // Read mux: unmapped, write-only and out-of-window locations return 0
    always_comb begin
        w_rdata = '0;
        if (w_in_win) begin
            case (w_off)
                OFF_CTRL:     w_rdata[CTRL_RUN_BIT] = w_run;
                OFF_STATUS: begin
                    w_rdata[STATUS_CNT_W-1:0]  = r_cnt;
                    w_rdata[STATUS_RUN_BIT]    = w_run;
                end
`ifdef WB_CTRL_IMEM_AUTOINC_EN
                OFF_IMEM_PTR: w_rdata = 32'(w_ptr);
`endif
                default: begin
                    for (int i = 0; i < NUM_CFG; i++) begin
                        if (w_off == OFF_CFG0 + 8'(4 * i)) w_rdata = w_cfg[i];
                    end
                end
            endcase
        end
    end

    // Handshake, registered read data, IMEM strobe and write counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_imem_we   <= 1'b0;
            r_imem_addr <= '0;
            r_imem_data <= '0;
            r_cnt       <= '0;
        end else begin
            r_ack     <= w_acc;
            r_dat     <= (w_acc && !wbs_we_i) ? w_rdata : '0;
            r_imem_we <= w_imem_fire;
            if (w_imem_fire) begin
                r_imem_addr <= w_imem_addr_nxt;
                r_imem_data <= wbs_dat_i[IMEM_DW-1:0];
                if (r_cnt != {STATUS_CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign imem_we_o   = r_imem_we;
    assign imem_addr_o = r_imem_addr;
    assign imem_data_o = r_imem_data;
    assign core_run_o  = w_run;
    assign cfg_o       = w_cfg;

endmodule
